// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; results are handed off through a valid/ready handshake.
module div_unit #(
    parameter int DataWidth = 32,
    parameter int CntWidth  = $clog2(DataWidth) + 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [1:0]           i_op,
    input  logic [DataWidth-1:0] i_a,
    input  logic [DataWidth-1:0] i_b,
    input  logic                 i_kill,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DataWidth-1:0] o_res,
    output logic                 o_busy
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t                 state;
    logic [CntWidth-1:0]    counter;
    logic [DataWidth-1:0]   divisor;
    logic [DataWidth-1:0]   quo;
    logic [DataWidth-1:0]   rem;
    logic                   is_rem;
    logic                   neg_q;
    logic                   neg_r;

    // Decode of the operation presented at the input.
    logic                   in_signed;
    logic                   in_rem;
    logic                   a_neg;
    logic                   b_neg;
    logic [DataWidth-1:0]   abs_a;
    logic [DataWidth-1:0]   abs_b;
    logic                   div_zero;
    logic                   sign_ovf;
    logic                   accept;

    // Datapath for one shift-subtract step and for sign fix-up.
    logic [DataWidth:0]     shifted;
    logic [DataWidth:0]     trial;
    logic [DataWidth-1:0]   q_fix;
    logic [DataWidth-1:0]   r_fix;

    always_comb begin
        in_signed = ~i_op[0];
        in_rem    = i_op[1];
        a_neg     = in_signed & i_a[DataWidth-1];
        b_neg     = in_signed & i_b[DataWidth-1];
        abs_a     = a_neg ? (~i_a + 1'b1) : i_a;
        abs_b     = b_neg ? (~i_b + 1'b1) : i_b;
        div_zero  = (i_b == '0);
        sign_ovf  = in_signed && (i_a == {1'b1, {(DataWidth-1){1'b0}}}) && (i_b == '1);
        accept    = i_valid && o_ready && !i_kill;
    end

    // The partial remainder is one bit wider than the operands during the step,
    // so the trial subtraction can never overflow; bit DataWidth is the borrow.
    always_comb begin
        shifted = {rem, quo[DataWidth-1]};
        trial   = shifted - {1'b0, divisor};
        q_fix   = neg_q ? (~quo + 1'b1) : quo;
        r_fix   = neg_r ? (~rem + 1'b1) : rem;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            counter <= '0;
            divisor <= '0;
            quo     <= '0;
            rem     <= '0;
            is_rem  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            o_valid <= 1'b0;
            o_res   <= '0;
            o_busy  <= 1'b0;
            o_ready <= 1'b1;
        end else if (i_kill) begin
            state   <= IDLE;
            counter <= '0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            o_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_rem  <= in_rem;
                        neg_q   <= ~in_rem & (a_neg ^ b_neg);
                        neg_r   <= in_rem & a_neg;
                        divisor <= abs_b;
                        quo     <= abs_a;
                        rem     <= '0;
                        counter <= '0;
                        o_ready <= 1'b0;
                        if (div_zero) begin
                            state   <= DONE;
                            o_valid <= 1'b1;
                            o_res   <= in_rem ? i_a : '1;
                        end else if (sign_ovf) begin
                            state   <= DONE;
                            o_valid <= 1'b1;
                            o_res   <= in_rem ? '0 : i_a;
                        end else begin
                            state   <= CALC;
                            o_busy  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (trial[DataWidth]) begin
                        rem <= shifted[DataWidth-1:0];
                        quo <= {quo[DataWidth-2:0], 1'b0};
                    end else begin
                        rem <= trial[DataWidth-1:0];
                        quo <= {quo[DataWidth-2:0], 1'b1};
                    end
                    if (counter == CntWidth'(DataWidth - 1)) begin
                        state   <= FIX;
                        counter <= '0;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                FIX: begin
                    o_res   <= is_rem ? r_fix : q_fix;
                    o_valid <= 1'b1;
                    o_busy  <= 1'b0;
                    state   <= DONE;
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: an arithmetic reference model tracks the handshake
// cycle by cycle while directed vectors pin results and latencies to literals.
module tb_div_unit;

    localparam int W = 32;

    logic          i_clk;
    logic          i_rst;
    logic          i_valid;
    logic          o_ready;
    logic [1:0]    i_op;
    logic [W-1:0]  i_a;
    logic [W-1:0]  i_b;
    logic          i_kill;
    logic          o_valid;
    logic          i_ready;
    logic [W-1:0]  o_res;
    logic          o_busy;

    int tests = 0;
    int fails = 0;

    div_unit #(.DataWidth(W)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_op    (i_op),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_kill  (i_kill),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_res   (o_res),
        .o_busy  (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RV32M semantics straight from the ISA rules, using SV arithmetic.
    function automatic logic is_special(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
        case (op)
            2'b00:   return $unsigned($signed(a) / $signed(b));
            2'b01:   return a / b;
            2'b10:   return $unsigned($signed(a) % $signed(b));
            default: return a % b;
        endcase
    endfunction

    // Transaction-level model: accepted op, its result, and edges left until valid.
    logic          m_active;
    logic [W-1:0]  m_res;
    int            m_left;

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_active <= 1'b0;
            m_left   <= 0;
        end else if (i_kill) begin
            m_active <= 1'b0;
        end else if (!m_active) begin
            if (i_valid) begin
                m_active <= 1'b1;
                m_res    <= model(i_op, i_a, i_b);
                m_left   <= is_special(i_op, i_a, i_b) ? 0 : W + 1;
            end
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
        end else if (i_ready) begin
            m_active <= 1'b0;
        end
    end

    always @(negedge i_clk) begin
        if (!i_rst) begin
            check("cyc o_valid", W'(o_valid), W'(m_active && m_left == 0));
            check("cyc o_busy",  W'(o_busy),  W'(m_active && m_left != 0));
            check("cyc o_ready", W'(o_ready), W'(!m_active));
            if (m_active && m_left == 0) check("cyc o_res", o_res, m_res);
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge i_clk);
        while (!o_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_ready) check("wait o_ready timeout", W'(o_ready), W'(1));
    endtask

    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input int lat, input int hold, input string name);
        int n;
        wait_ready();
        i_op = op; i_a = a; i_b = b; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_a = $urandom; i_b = $urandom; i_op = 2'($urandom);
        n = 1;
        while (!o_valid && n < 200) begin
            @(posedge i_clk); #1;
            n++;
        end
        check({name, " latency"}, W'(n), W'(lat));
        check({name, " result"}, o_res, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge i_clk); #1;
            check({name, " hold valid"}, W'(o_valid), W'(1));
            check({name, " hold res"}, o_res, exp);
        end
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        check({name, " ready after consume"}, W'(o_ready), W'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        i_rst = 1'b1; i_valid = 1'b0; i_op = 2'b00; i_a = '0; i_b = '0;
        i_kill = 1'b0; i_ready = 1'b0;
        repeat (3) @(negedge i_clk);
        check("reset o_valid", W'(o_valid), W'(0));
        check("reset o_res", o_res, '0);
        check("reset o_busy", W'(o_busy), W'(0));
        #2 i_rst = 1'b0;
        #1 check("reset o_ready", W'(o_ready), W'(1));

        do_op(2'b00, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 34, 0, "DIV -20/3");
        do_op(2'b10, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 34, 0, "REM -20/3");
        do_op(2'b01, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 34, 5, "DIVU max/2");
        do_op(2'b11, 32'hFFFF_FFFF, 32'd2, 32'h1, 34, 0, "REMU max/2");
        do_op(2'b00, 32'd7, 32'd0, 32'hFFFF_FFFF, 1, 0, "DIV 7/0");
        do_op(2'b11, 32'd7, 32'd0, 32'd7, 1, 0, "REMU 7/0");
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "DIV ovf");
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 2, "REM ovf");
        do_op(2'b10, 32'd20, 32'hFFFF_FFFD, 32'd2, 34, 0, "REM 20/-3");

        // Kill at iteration 10 of a DIVU.
        wait_ready();
        i_op = 2'b01; i_a = 32'd100; i_b = 32'd7; i_valid = 1'b1;
        @(posedge i_clk); #1 i_valid = 1'b0;
        repeat (10) @(posedge i_clk);
        @(negedge i_clk) i_kill = 1'b1;
        @(posedge i_clk); #1;
        i_kill = 1'b0;
        check("kill o_valid", W'(o_valid), W'(0));
        check("kill o_ready", W'(o_ready), W'(1));
        check("kill o_busy", W'(o_busy), W'(0));
        do_op(2'b01, 32'd100, 32'd7, 32'd14, 34, 0, "DIVU after kill");

        // Asynchronous reset mid-CALC.
        wait_ready();
        i_op = 2'b01; i_a = 32'd100; i_b = 32'd7; i_valid = 1'b1;
        @(posedge i_clk); #1 i_valid = 1'b0;
        repeat (5) @(posedge i_clk);
        @(negedge i_clk); #2 i_rst = 1'b1;
        #1;
        check("rst mid o_valid", W'(o_valid), W'(0));
        check("rst mid o_res", o_res, '0);
        check("rst mid o_busy", W'(o_busy), W'(0));
        @(negedge i_clk); #2 i_rst = 1'b0;
        do_op(2'b01, 32'd9, 32'd3, 32'd3, 34, 0, "DIVU after rst");

        // Back-to-back with i_valid held high.
        wait_ready();
        i_op = 2'b11; i_a = 32'd100; i_b = 32'd7; i_valid = 1'b1;
        @(posedge i_clk); #1;
        n = 0;
        while (!o_valid && n < 200) begin @(posedge i_clk); #1; n++; end
        check("b2b first", o_res, 32'd2);
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        i_op = 2'b01; i_a = 32'd9; i_b = 32'd3;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        check("b2b second accepted", W'(o_ready), W'(0));
        n = 0;
        while (!o_valid && n < 200) begin @(posedge i_clk); #1; n++; end
        check("b2b second", o_res, 32'd3);
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        repeat (3) @(posedge i_clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 divide/remainder unit for the execute stage, covering RV32M DIV, DIVU, REM and REMU.
- Consumes the same decoded operands the ALU receives and runs alongside it. The ALU's single-cycle divide path is removed once this unit is integrated.
- Results go to the execute/writeback result mux through a valid/ready handshake, so the pipeline stalls while a divide is in flight.

Parameters:
- DataWidth, 32, operand and result width in bits; must be at least 4.
- CntWidth, $clog2(DataWidth)+1, width of the iteration counter.

Ports:
- i_clk  input  1  clock; all state updates on its rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  upstream presents a divide operation.
- o_ready  output  1  unit can accept an operation; high only in IDLE.
- i_op  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- i_a  input  DataWidth  dividend.
- i_b  input  DataWidth  divisor.
- i_kill  input  1  pipeline flush; discards any operation in flight.
- o_valid  output  1  o_res holds a completed result.
- i_ready  input  1  downstream consumes o_res.
- o_res  output  DataWidth  quotient or remainder.
- o_busy  output  1  high in CALC or FIX; used by hazard logic.

Behaviour:
- Reset: the async i_rst forces state IDLE, o_valid=0, o_res=0, o_busy=0 and counter=0. o_ready=1 after reset is released. An i_rst assertion mid-operation discards all work.
- States:
  - IDLE: accept when i_valid && o_ready. Latch op and operand signs. Load absolute values for signed ops, raw values for unsigned ops.
    - Special case, divide by zero (i_b==0): go directly to DONE. Quotient result = all ones; remainder result = i_a.
    - Special case, signed overflow (DIV/REM with i_a=most negative, i_b=all ones): go directly to DONE. DIV result = i_a; REM result = 0.
    - Otherwise: go to CALC with counter=0.
  - CALC: one restoring shift-subtract step per cycle. The partial remainder is DataWidth+1 bits, so there is no overflow on subtract. After DataWidth steps (counter==DataWidth-1 at the edge), go to FIX.
  - FIX: apply signs.
    - Quotient is negated when the operand signs differ (DIV only).
    - Remainder takes the dividend's sign (REM only).
    - Load o_res and go to DONE.
  - DONE: o_valid=1 and o_res holds stable. On i_ready go to IDLE; o_ready rises the next cycle.
- Latency, counted from the accepting edge:
  - Normal operation: o_valid rises after DataWidth+2 edges (34 for DataWidth=32).
  - Special cases: o_valid rises after 1 edge.
- Throughput: one operation at a time. There is no accept in the same cycle DONE is consumed.
- i_kill:
  - Synchronous.
  - Any state goes to IDLE next edge with o_valid=0. o_res keeps its last value.
  - i_kill overrides i_valid; no accept happens that cycle.
  - i_kill in DONE together with i_ready: the result is treated as not delivered.
- Operand capture: i_a, i_b and i_op are sampled only on the accept edge. Changes afterwards have no effect.
- o_busy = (state==CALC || state==FIX).

Test Plan:
- DIV a=-20 (0xFFFFFFEC), b=3 -> o_res=0xFFFFFFFA (-6), o_valid 34 cycles after accept. REM with the same operands -> 0xFFFFFFFE (-2).
- DIVU a=0xFFFFFFFF, b=2 -> 0x7FFFFFFF. REMU with the same operands -> 1. Hold i_ready=0 for 5 cycles: o_res stable and o_valid held.
- DIV a=7, b=0 -> 0xFFFFFFFF; REMU a=7, b=0 -> 7. Both with o_valid one cycle after accept.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0. Both one cycle after accept.
- Accept DIVU 100/7, assert i_kill at iteration 10 -> no o_valid. o_ready=1 next cycle, then a new DIVU 100/7 -> 14. Repeat with i_rst asserted mid-CALC: outputs are immediately 0.
- Back-to-back: hold i_valid high with two operations (REMU 100/7 then DIVU 9/3) -> 2 then 3 delivered in order. o_ready is low throughout each operation.
